pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
// - Generic, parametrised pipeline stage register between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Carries a DATA_W payload plus a CTRL_W control vector under a valid/ready handshake.
// - Supports flush (bubble insertion) and an optional 1-entry skid buffer, so backpressure needs no combinational ready path.
// - Control bits are forced to 0 on any bubble, so downstream stages see a NOP (no reg/mem write).
// PARAMETERS
// - DATA_W  101  payload width (EX/MEM: pc_plus_4 32 + alu_result 32 + rdata2 32 + rd 5)
// - CTRL_W  6    control width, zeroed on bubble (EX/MEM: mem_write 2, mem_read 1, reg_write 1, result_src 2)
// - SKID    1    1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
// PORTS
// - clk        in   1       clock, rising edge
// - reset      in   1       asynchronous, active-high
// - flush      in   1       synchronous: kill all held beats and the incoming beat
// - in_valid   in   1       upstream beat present
// - in_ready   out  1       stage can accept a beat this cycle
// - in_data    in   DATA_W  upstream payload
// - in_ctrl    in   CTRL_W  upstream control
// - out_valid  out  1       beat presented downstream
// - out_ready  in   1       downstream accepts (0 = stall)
// - out_data   out  DATA_W  payload of head beat
// - out_ctrl   out  CTRL_W  control of head beat; 0 whenever out_valid = 0
// - occupancy  out  2       beats held (0..1 when SKID=0, 0..2 when SKID=1)
// BEHAVIOUR
// - Reset (async): out_valid=0, out_data=0, out_ctrl=0, occupancy=0, skid entry invalid; in_ready=1 once reset deasserts.
// - Transfer in: in_valid & in_ready at a posedge. Transfer out: out_valid & out_ready at a posedge.
// - Latency: an accepted beat appears on out_* on the next cycle if the main register is empty or drains that cycle.
// - Order: strictly FIFO. Payload and ctrl never change while out_valid & !out_ready.
// - SKID=0: in_ready = !out_valid | out_ready (combinational). Main reg loads on in transfer.
//   out_valid clears on an out transfer with no in transfer.
// - SKID=1: in_ready = !skid_valid (registered). Four states by (main_valid, skid_valid): EMPTY(0,0), ONE(1,0), FULL(1,1); (0,1) unreachable.
//   EMPTY: in xfer -> ONE (main<=in).
//   ONE: in&out -> ONE (main<=in). Out only -> EMPTY. In only (stall) -> FULL (skid<=in).
//   FULL: out xfer -> ONE (main<=skid); no input accepted since in_ready=0.
// - Full throughput: 1 beat/cycle sustained while out_ready=1, both modes.
// - Flush: at the posedge with flush=1, main_valid=skid_valid=0 and ctrl regs cleared; data regs may hold stale values.
//   The in_valid beat that cycle completes its handshake (if in_ready) and is discarded. Flush beats stall and in transfer.
// - Flush with out_ready=1 the same cycle: the head beat counts as transferred (downstream already sampled it); nothing else survives.
// - out_ctrl is driven from the ctrl register, never gated by logic; bubbles load CTRL=0 explicitly. out_data is don't-care when out_valid=0.
// - occupancy = main_valid + skid_valid; registered, no glitch.
// - Reset mid-operation: all held beats lost immediately, regardless of handshake state.
// STRUCTURE
// - Package pipe_pkg: typedef ex_mem_data_t (pc_plus_4, alu_result, rdata2, rd) and ex_mem_ctrl_t (mem_write, mem_read, reg_write, result_src).
//   Constants EX_MEM_DATA_W=101, EX_MEM_CTRL_W=6, CTRL_NOP='0.
// - Sub-module pipe_slot: one valid+ctrl+data register with load/clear (async reset, sync clear). Instantiated once for main, plus once for skid under generate when SKID=1.
// - Top: occupancy FSM, in_ready generation, mux of in vs skid into main.
// TESTING
// - Reset: hold reset with in_valid=1 -> out_valid=0, out_ctrl=0, occupancy=0; after release, in_ready=1.
// - Stream: 8 beats, data=i, ctrl=6'h3F, out_ready=1 -> each beat out 1 cycle later, no gaps, in_ready stays 1.
// - Stall (SKID=1): out_ready=0 for 3 cycles while sending A,B,C -> A held on out, B in skid, in_ready=0, C held upstream.
//   Release -> A,B,C in order, back-to-back.
// - Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; incoming beat never appears.
// - Flush + out_ready=1 same cycle -> head counted once, no duplicate; following beat after flush emerges normally.
// - SKID=0 config: random in_valid/out_ready 10k cycles vs scoreboard -> order kept, no loss/duplication, in_ready == !out_valid|out_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-register types, widths and occupancy states
package pipe_pkg;

    localparam int EX_MEM_DATA_W = 101;
    localparam int EX_MEM_CTRL_W = 6;

    typedef struct packed {
        logic [31:0] pc_plus_4;
        logic [31:0] alu_result;
        logic [31:0] rdata2;
        logic [4:0]  rd;
    } ex_mem_data_t;

    typedef struct packed {
        logic [1:0] mem_write;
        logic       mem_read;
        logic       reg_write;
        logic [1:0] result_src;
    } ex_mem_ctrl_t;

    localparam logic [EX_MEM_CTRL_W-1:0] CTRL_NOP = '0;

    // encoding equals the number of beats held, so it doubles as occupancy
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid+ctrl+data register; clear turns it into a NOP bubble
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = EX_MEM_DATA_W,
    parameter int CTRL_W = EX_MEM_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // clear wins over load; data is left stale on clear since it is don't-care when invalid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= CTRL_W'(CTRL_NOP);
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with flush and optional skid entry
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = EX_MEM_DATA_W,
    parameter int CTRL_W = EX_MEM_CTRL_W,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              main_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              in_xfer;
    logic              out_xfer;
    logic              main_load;
    logic              main_clear;
    logic              skid_load;
    logic              skid_clear;
    occ_state_t        state;

    assign out_valid = main_valid;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // main refills from skid first (FIFO order), else from input when it is empty or draining
    assign main_load  = !flush & ((skid_valid & out_xfer) | (in_xfer & (!main_valid | out_xfer)));
    assign main_clear = flush | (out_xfer & !in_xfer & !skid_valid);
    // skid catches the beat that arrives while the head is stalled
    assign skid_load  = !flush & in_xfer & main_valid & !out_xfer;
    assign skid_clear = flush | (skid_valid & out_xfer);

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) main_slot (
        .clk    (clk),
        .reset  (reset),
        .load   (main_load),
        .clear  (main_clear),
        .d_data (skid_valid ? skid_data : in_data),
        .d_ctrl (skid_valid ? skid_ctrl : in_ctrl),
        .valid  (main_valid),
        .data   (out_data),
        .ctrl   (out_ctrl)
    );

    generate
        if (SKID) begin : g_skid
            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) skid_slot (
                .clk    (clk),
                .reset  (reset),
                .load   (skid_load),
                .clear  (skid_clear),
                .d_data (in_data),
                .d_ctrl (in_ctrl),
                .valid  (skid_valid),
                .data   (skid_data),
                .ctrl   (skid_ctrl)
            );
            assign in_ready = !skid_valid;
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign skid_ctrl  = CTRL_W'(CTRL_NOP);
            assign in_ready   = !main_valid | out_ready;
        end
    endgenerate

    // occupancy FSM; its state register is the glitch-free occupancy output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= OCC_EMPTY;
        end else if (flush) begin
            state <= OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: state <= in_xfer ? OCC_ONE : OCC_EMPTY;
                OCC_ONE:   state <= (out_xfer & !in_xfer) ? OCC_EMPTY :
                                    (in_xfer & !out_xfer) ? OCC_FULL : OCC_ONE;
                OCC_FULL:  state <= out_xfer ? OCC_ONE : OCC_FULL;
                default:   state <= OCC_EMPTY;
            endcase
        end
    end

    assign occupancy = state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: queue-model checking of both SKID configurations plus directed literals
module tb_pipe_stage_skid;

    typedef struct packed {
        logic [100:0] d;
        logic [5:0]   c;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset, flush, in_valid, out_ready;
    logic [100:0] in_data;
    logic [5:0]   in_ctrl;
    logic         ir1, ov1, ir0, ov0;
    logic [100:0] od1, od0;
    logic [5:0]   oc1, oc0;
    logic [1:0]   occ1, occ0;
    int           n_cmp = 0;
    int           n_bad = 0;
    beat_t        q1[$];
    beat_t        q0[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(101), .CTRL_W(6), .SKID(1'b1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .out_ctrl(oc1), .occupancy(occ1)
    );

    pipe_stage_skid #(.DATA_W(101), .CTRL_W(6), .SKID(1'b0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov0), .out_ready(out_ready),
        .out_data(od0), .out_ctrl(oc0), .occupancy(occ0)
    );

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic cmp(input string n, input int sz, input beat_t head, input bit exp_ir,
                       input logic ov, input logic ir, input logic [1:0] occ,
                       input logic [100:0] od, input logic [5:0] oc);
        chk({n, " out_valid"}, ov, sz > 0);
        chk({n, " occupancy"}, occ, sz);
        chk({n, " in_ready"}, ir, exp_ir);
        chk({n, " out_ctrl"}, oc, sz > 0 ? head.c : 6'h0);
        if (sz > 0) chk({n, " out_data"}, od, head.d);
    endtask

    // transaction-level model: held beats are a FIFO of at most 2 (skid) or 1 (no skid)
    always @(posedge clk or posedge reset) begin : model
        bit r1, r0;
        if (reset) begin
            q1.delete();
            q0.delete();
        end else begin
            r1 = q1.size() < 2;
            r0 = q0.size() == 0 || out_ready;
            if (q1.size() > 0 && out_ready) void'(q1.pop_front());
            if (q0.size() > 0 && out_ready) void'(q0.pop_front());
            if (in_valid && r1) q1.push_back({in_data, in_ctrl});
            if (in_valid && r0) q0.push_back({in_data, in_ctrl});
            if (flush) begin
                q1.delete();
                q0.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            cmp("skid1", q1.size(), q1.size() > 0 ? q1[0] : '0, q1.size() < 2,
                ov1, ir1, occ1, od1, oc1);
            cmp("skid0", q0.size(), q0.size() > 0 ? q0[0] : '0, q0.size() == 0 || out_ready,
                ov0, ir0, occ0, od0, oc0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [100:0] d, input logic [5:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        tick();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 101'h55; in_ctrl = 6'h3F; out_ready = 1'b0;
        repeat (3) tick();
        chk("rst out_valid", ov1, 0);
        chk("rst out_ctrl", oc1, 0);
        chk("rst occupancy", occ1, 0);
        chk("rst out_valid0", ov0, 0);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("post-rst in_ready", ir1, 1);
        chk("post-rst in_ready0", ir0, 1);

        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(101'(i), 6'h3F);
            chk("stream out_valid", ov1, 1);
            chk("stream out_data", od1, i);
            chk("stream out_ctrl", oc1, 6'h3F);
            chk("stream in_ready", ir1, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream drained", ov1, 0);

        out_ready = 1'b0;
        send(101'hA, 6'h01);
        send(101'hB, 6'h02);
        send(101'hC, 6'h03);
        chk("stall occupancy", occ1, 2);
        chk("stall in_ready", ir1, 0);
        chk("stall head", od1, 101'hA);
        out_ready = 1'b1;
        tick();
        chk("release B", od1, 101'hB);
        chk("release B occ", occ1, 1);
        tick();
        chk("release C", od1, 101'hC);
        chk("release C ctrl", oc1, 6'h03);
        in_valid = 1'b0;
        tick();
        chk("release empty", ov1, 0);

        out_ready = 1'b0;
        send(101'hD, 6'h11);
        send(101'hE, 6'h12);
        chk("pre-flush occ", occ1, 2);
        flush = 1'b1;
        send(101'hF, 6'h13);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush out_valid", ov1, 0);
        chk("flush out_ctrl", oc1, 0);
        chk("flush occupancy", occ1, 0);
        tick();
        chk("flush no ghost", ov1, 0);

        send(101'h1234, 6'h15);
        chk("G held", od1, 101'h1234);
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush+out empty", ov1, 0);
        send(101'h5678, 6'h2A);
        chk("after flush data", od1, 101'h5678);
        chk("after flush ctrl", oc1, 6'h2A);
        chk("after flush occ", occ1, 1);
        in_valid = 1'b0;
        tick();
        chk("after flush drained", ov1, 0);

        out_ready = 1'b0;
        send(101'h77, 6'h05);
        send(101'h88, 6'h06);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid-reset out_valid", ov1, 0);
        chk("mid-reset occupancy", occ1, 0);
        chk("mid-reset out_ctrl", oc1, 0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 63) == 0;
            in_data   = {$urandom(), $urandom(), $urandom(), 5'($urandom_range(0, 31))};
            in_ctrl   = 6'($urandom_range(0, 63));
            tick();
        end
        in_valid = 1'b0; flush = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
